// File: rtl/collision_pkg.sv
// Shared types and default constants for the tank collision engine.
package collision_pkg;

  localparam int NUM_TANKS_DEF        = 2;
  localparam int BULLETS_PER_TANK_DEF = 3;
  localparam int POS_W_DEF            = 10;
  localparam int TANK_SIZE_DEF        = 32;
  localparam int LIVES_DEF            = 3;

  typedef logic [POS_W_DEF-1:0] pos_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/box_hit_test.sv
// Strict point-inside-square test; box end is formed one bit wider so it never wraps.
module box_hit_test #(
  parameter int POS_W     = 10,
  parameter int TANK_SIZE = 32
) (
  input  logic [POS_W-1:0] px,
  input  logic [POS_W-1:0] py,
  input  logic [POS_W-1:0] bx,
  input  logic [POS_W-1:0] by,
  output logic             hit
);

  logic [POS_W:0] bx_end;
  logic [POS_W:0] by_end;

  assign bx_end = {1'b0, bx} + (POS_W+1)'(TANK_SIZE);
  assign by_end = {1'b0, by} + (POS_W+1)'(TANK_SIZE);

  assign hit = (px > bx) && ({1'b0, px} < bx_end) &&
               (py > by) && ({1'b0, py} < by_end);

endmodule

// File: rtl/collision_engine.sv
// Per-frame bullet/tank collision scan: one (shooter, slot, target) triple per cycle,
// hit pulses in COMMIT, lives bookkeeping and game-over detection.
module collision_engine
  import collision_pkg::*;
#(
  parameter int NUM_TANKS        = NUM_TANKS_DEF,
  parameter int BULLETS_PER_TANK = BULLETS_PER_TANK_DEF,
  parameter int POS_W            = POS_W_DEF,
  parameter int TANK_SIZE        = TANK_SIZE_DEF,
  parameter int LIVES            = LIVES_DEF
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        frame_tick,
  input  logic [NUM_TANKS*BULLETS_PER_TANK*POS_W-1:0] bullet_x,
  input  logic [NUM_TANKS*BULLETS_PER_TANK*POS_W-1:0] bullet_y,
  input  logic [NUM_TANKS*BULLETS_PER_TANK-1:0]       bullet_active,
  input  logic [NUM_TANKS*POS_W-1:0]                  tank_x,
  input  logic [NUM_TANKS*POS_W-1:0]                  tank_y,
  output logic [NUM_TANKS*BULLETS_PER_TANK-1:0]       bullet_hit,
  output logic [NUM_TANKS-1:0]                        tank_hit,
  output logic [NUM_TANKS*4-1:0]                      lives,
  output logic                                        busy,
  output logic                                        frame_overrun,
  output logic                                        game_over,
  output logic [1:0]                                  winner,
  output logic                                        draw
);

  localparam int NB = NUM_TANKS * BULLETS_PER_TANK;

  state_t state, state_nx;

  logic [1:0]                 sh, sl, tg;
  logic [NB*POS_W-1:0]        sbx, sby;
  logic [NB-1:0]              sact;
  logic [NUM_TANKS*POS_W-1:0] stx, sty;
  logic [NB-1:0]              bflags;
  logic [NUM_TANKS-1:0]       tflags;
  logic [NUM_TANKS*4-1:0]     lives_q;

  logic [3:0]       bidx;
  logic [POS_W-1:0] cur_bx, cur_by, cur_tx, cur_ty;
  logic [NB-1:0]    act_vec;
  logic             cur_act;
  logic [3:0]       sh_lives, tg_lives;
  logic             box_hit, pair_hit, last_pair, accept;
  logic [2:0]       alive_cnt;
  logic [1:0]       low_idx;

  // Current triple, selected from the frame snapshot
  assign bidx     = 4'(sh) * 4'(BULLETS_PER_TANK) + 4'(sl);
  assign cur_bx   = sbx[bidx*POS_W +: POS_W];
  assign cur_by   = sby[bidx*POS_W +: POS_W];
  assign cur_tx   = stx[tg*POS_W +: POS_W];
  assign cur_ty   = sty[tg*POS_W +: POS_W];
  assign act_vec  = sact >> bidx;
  assign cur_act  = act_vec[0];
  assign sh_lives = lives_q[sh*4 +: 4];
  assign tg_lives = lives_q[tg*4 +: 4];

  box_hit_test #(
    .POS_W     (POS_W),
    .TANK_SIZE (TANK_SIZE)
  ) u_box_hit_test (
    .px  (cur_bx),
    .py  (cur_by),
    .bx  (cur_tx),
    .by  (cur_ty),
    .hit (box_hit)
  );

  assign pair_hit  = (state == ST_SCAN) && box_hit && cur_act && (sh != tg) &&
                     (sh_lives != 4'd0) && (tg_lives != 4'd0);
  assign last_pair = (sh == 2'(NUM_TANKS-1)) && (sl == 2'(BULLETS_PER_TANK-1)) &&
                     (tg == 2'(NUM_TANKS-1));
  assign accept    = (state == ST_IDLE) && frame_tick && !game_over;

  assign busy       = (state != ST_IDLE);
  assign bullet_hit = (state == ST_COMMIT) ? bflags : '0;
  assign tank_hit   = (state == ST_COMMIT) ? tflags : '0;
  assign lives      = lives_q;

  always_comb begin
    alive_cnt = '0;
    low_idx   = '0;
    for (int i = NUM_TANKS-1; i >= 0; i--) begin
      if (lives_q[i*4 +: 4] != 4'd0) begin
        alive_cnt = alive_cnt + 3'd1;
        low_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_SCAN;
      ST_SCAN:   if (last_pair) state_nx = ST_COMMIT;
      ST_COMMIT: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      sh            <= '0;
      sl            <= '0;
      tg            <= '0;
      sbx           <= '0;
      sby           <= '0;
      sact          <= '0;
      stx           <= '0;
      sty           <= '0;
      bflags        <= '0;
      tflags        <= '0;
      lives_q       <= {NUM_TANKS{4'(LIVES)}};
      frame_overrun <= 1'b0;
      game_over     <= 1'b0;
      winner        <= '0;
      draw          <= 1'b0;
    end else begin
      state <= state_nx;
      if (frame_tick && busy) frame_overrun <= 1'b1;

      if (accept) begin
        sbx    <= bullet_x;
        sby    <= bullet_y;
        sact   <= bullet_active;
        stx    <= tank_x;
        sty    <= tank_y;
        bflags <= '0;
        tflags <= '0;
        sh     <= '0;
        sl     <= '0;
        tg     <= '0;
      end

      // Target is the fastest-moving index, shooter the slowest
      if (state == ST_SCAN) begin
        if (pair_hit) begin
          bflags <= bflags | (NB'(1) << bidx);
          tflags <= tflags | (NUM_TANKS'(1) << tg);
        end
        if (tg == 2'(NUM_TANKS-1)) begin
          tg <= '0;
          if (sl == 2'(BULLETS_PER_TANK-1)) begin
            sl <= '0;
            sh <= sh + 2'd1;
          end else begin
            sl <= sl + 2'd1;
          end
        end else begin
          tg <= tg + 2'd1;
        end
      end

      // One life per hit tank per frame, however many bullets landed
      if (state == ST_COMMIT) begin
        for (int i = 0; i < NUM_TANKS; i++) begin
          if (tflags[i] && (lives_q[i*4 +: 4] != 4'd0))
            lives_q[i*4 +: 4] <= lives_q[i*4 +: 4] - 4'd1;
        end
      end

      if (!game_over && (alive_cnt <= 3'd1)) begin
        game_over <= 1'b1;
        draw      <= (alive_cnt == 3'd0);
        winner    <= low_idx;
      end
    end
  end

endmodule

// File: tb/tb_collision_engine.sv
// Bench for collision_engine: frame-level reference model, per-cycle compare, directed pins.
module tb_collision_engine;

  localparam int NT  = 2;
  localparam int NBT = 3;
  localparam int PW  = 10;
  localparam int NB  = NT * NBT;
  localparam int TS  = 32;
  localparam int LV  = 3;
  localparam int P   = NT * NBT * NT;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0;
  always #5 clock = ~clock;

  int bx [NB];
  int by [NB];
  int tx [NT];
  int ty [NT];
  logic [NB-1:0] bullet_active = '0;

  logic [NB*PW-1:0] bullet_x, bullet_y;
  logic [NT*PW-1:0] tank_x, tank_y;
  logic [NB-1:0]    bullet_hit;
  logic [NT-1:0]    tank_hit;
  logic [NT*4-1:0]  lives;
  logic             busy, frame_overrun, game_over, draw;
  logic [1:0]       winner;

  always_comb begin
    bullet_x = '0;
    bullet_y = '0;
    tank_x   = '0;
    tank_y   = '0;
    for (int i = 0; i < NB; i++) begin
      bullet_x[i*PW +: PW] = PW'(bx[i]);
      bullet_y[i*PW +: PW] = PW'(by[i]);
    end
    for (int i = 0; i < NT; i++) begin
      tank_x[i*PW +: PW] = PW'(tx[i]);
      tank_y[i*PW +: PW] = PW'(ty[i]);
    end
  end

  collision_engine dut (
    .clock         (clock),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .tank_x        (tank_x),
    .tank_y        (tank_y),
    .bullet_hit    (bullet_hit),
    .tank_hit      (tank_hit),
    .lives         (lives),
    .busy          (busy),
    .frame_overrun (frame_overrun),
    .game_over     (game_over),
    .winner        (winner),
    .draw          (draw)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a frame is resolved as a whole when accepted; the result
  // is shown P+1 cycles later and lives change one cycle after that.
  int            m_lives [NT];
  int            m_phase;
  logic [NB-1:0] m_pb;
  logic [NT-1:0] m_pt;
  bit            m_ovr, m_go, m_draw, m_valid;
  int            m_win;
  bit            m_was_busy, m_acc;
  int            m_alive, m_low;

  always @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < NT; t++) m_lives[t] = LV;
      m_phase = 0;
      m_pb    = '0;
      m_pt    = '0;
      m_ovr   = 0;
      m_go    = 0;
      m_draw  = 0;
      m_win   = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_was_busy = (m_phase != 0);
      m_acc      = frame_tick && !m_was_busy && !m_go;
      if (frame_tick && m_was_busy) m_ovr = 1;
      m_alive = 0;
      m_low   = 0;
      for (int t = NT-1; t >= 0; t--)
        if (m_lives[t] > 0) begin
          m_alive++;
          m_low = t;
        end
      if (!m_go && m_alive <= 1) begin
        m_go   = 1;
        m_draw = (m_alive == 0);
        m_win  = m_low;
      end
      if (m_phase == P + 1) begin
        for (int t = 0; t < NT; t++)
          if (m_pt[t] && m_lives[t] > 0) m_lives[t]--;
        m_phase = 0;
      end else if (m_phase != 0) begin
        m_phase++;
      end else if (m_acc) begin
        m_pb = '0;
        m_pt = '0;
        for (int s = 0; s < NT; s++)
          for (int k = 0; k < NBT; k++)
            for (int t = 0; t < NT; t++) begin
              int b;
              b = s * NBT + k;
              if (s != t && bullet_active[b] && m_lives[s] > 0 && m_lives[t] > 0 &&
                  bx[b] > tx[t] && bx[b] < tx[t] + TS &&
                  by[b] > ty[t] && by[b] < ty[t] + TS) begin
                m_pb[b] = 1'b1;
                m_pt[t] = 1'b1;
              end
            end
        m_phase = 1;
      end
    end
  end

  // compare process
  logic [NT*4-1:0] exp_lives;
  always @(negedge clock) begin
    if (m_valid) begin
      for (int t = 0; t < NT; t++) exp_lives[t*4 +: 4] = 4'(m_lives[t]);
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("bullet_hit", 32'(bullet_hit), 32'((m_phase == P + 1) ? m_pb : '0));
      check("tank_hit", 32'(tank_hit), 32'((m_phase == P + 1) ? m_pt : '0));
      check("lives", 32'(lives), 32'(exp_lives));
      check("frame_overrun", 32'(frame_overrun), 32'(m_ovr));
      check("game_over", 32'(game_over), 32'(m_go));
      check("draw", 32'(draw), 32'(m_draw));
      if (m_go && !m_draw) check("winner", 32'(winner), 32'(m_win));
    end
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Returns at the negedge of cycle 1 (cycle 0 is the cycle sampling the tick).
  task automatic pulse_tick();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
  endtask

  task automatic clear_scene();
    for (int i = 0; i < NB; i++) begin
      bx[i] = 0;
      by[i] = 0;
    end
    bullet_active = '0;
    tx[0] = 400; ty[0] = 400;
    tx[1] = 100; ty[1] = 100;
  endtask

  task automatic set_bullet(input int i, input int x, input int y, input bit a);
    bx[i] = x;
    by[i] = y;
    bullet_active[i] = a;
  endtask

  // Runs one frame from a fresh tick and pins its pulses and lives literally.
  task automatic frame_expect(input string nm, input logic [NB-1:0] eb, input logic [NT-1:0] et,
                              input logic [NT*4-1:0] el);
    pulse_tick();
    repeat (11) @(negedge clock);
    check({nm, "_pre_pulse"}, 32'(tank_hit), 32'(0));
    @(negedge clock);
    check({nm, "_bullet_hit"}, 32'(bullet_hit), 32'(eb));
    check({nm, "_tank_hit"}, 32'(tank_hit), 32'(et));
    @(negedge clock);
    check({nm, "_lives"}, 32'(lives), 32'(el));
    check({nm, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic watch(input int n, output logic [NB-1:0] ob, output logic [NT-1:0] ot,
                       output logic obusy);
    ob = '0; ot = '0; obusy = 1'b0;
    repeat (n) begin
      @(negedge clock);
      ob = ob | bullet_hit;
      ot = ot | tank_hit;
      obusy = obusy | busy;
    end
  endtask

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
  endfunction

  task automatic random_scene();
    for (int t = 0; t < NT; t++) begin
      tx[t] = ($urandom_range(0, 3) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 120);
      ty[t] = ($urandom_range(0, 3) == 0) ? $urandom_range(960, 1023) : $urandom_range(0, 120);
    end
    for (int i = 0; i < NB; i++) begin
      int t;
      t = $urandom_range(0, NT - 1);
      bx[i] = clamp(tx[t] + $urandom_range(0, 40) - 4);
      by[i] = clamp(ty[t] + $urandom_range(0, 40) - 4);
      bullet_active[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  logic [NB-1:0] ob;
  logic [NT-1:0] ot;
  logic          obusy;
  int            mode;

  initial begin
    clear_scene();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset state
    check("rst_lives", 32'(lives), 32'(8'h33));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_game_over", 32'(game_over), 32'(0));
    check("rst_overrun", 32'(frame_overrun), 32'(0));
    check("rst_winner", 32'(winner), 32'(0));

    // single centred hit
    set_bullet(0, 116, 116, 1);
    frame_expect("basic", 6'b000001, 2'b10, 8'h23);

    // strict edges, then far corner without wrap
    do_reset(); clear_scene();
    set_bullet(0, 100, 116, 1);
    frame_expect("edge_left", 6'b0, 2'b0, 8'h33);
    set_bullet(0, 132, 116, 1);
    frame_expect("edge_right", 6'b0, 2'b0, 8'h33);
    tx[1] = 1000; ty[1] = 1000;
    set_bullet(0, 1020, 1020, 1);
    frame_expect("no_wrap", 6'b000001, 2'b10, 8'h23);

    // three bullets, one life
    do_reset(); clear_scene();
    set_bullet(0, 110, 110, 1);
    set_bullet(1, 116, 116, 1);
    set_bullet(2, 120, 125, 1);
    frame_expect("triple", 6'b000111, 2'b10, 8'h23);

    // own tank and inactive slot
    do_reset(); clear_scene();
    tx[0] = 300; ty[0] = 300;
    set_bullet(0, 310, 310, 1);
    set_bullet(1, 116, 116, 0);
    frame_expect("self_inactive", 6'b0, 2'b0, 8'h33);

    // kill tank1
    do_reset(); clear_scene();
    set_bullet(0, 116, 116, 1);
    frame_expect("kill1", 6'b000001, 2'b10, 8'h23);
    frame_expect("kill2", 6'b000001, 2'b10, 8'h13);
    frame_expect("kill3", 6'b000001, 2'b10, 8'h03);
    @(negedge clock);
    check("go_game_over", 32'(game_over), 32'(1));
    check("go_winner", 32'(winner), 32'(0));
    check("go_draw", 32'(draw), 32'(0));
    pulse_tick();
    watch(15, ob, ot, obusy);
    check("go_tick_ignored", 32'(obusy), 32'(0));

    // overrun without reset: exactly one scan
    do_reset(); clear_scene();
    set_bullet(0, 116, 116, 1);
    pulse_tick();
    repeat (3) @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    check("ovr_flag", 32'(frame_overrun), 32'(1));
    repeat (8) @(negedge clock);
    check("ovr_pulse", 32'(tank_hit), 32'(2'b10));
    @(negedge clock);
    check("ovr_lives", 32'(lives), 32'(8'h23));
    watch(15, ob, ot, obusy);
    check("ovr_single_scan", 32'(obusy), 32'(0));

    // overrun then reset mid-scan
    do_reset(); clear_scene();
    set_bullet(0, 116, 116, 1);
    pulse_tick();
    repeat (3) @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    check("abort_ovr_flag", 32'(frame_overrun), 32'(1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    watch(16, ob, ot, obusy);
    check("abort_no_pulse", 32'({ob, ot}), 32'(0));
    check("abort_lives", 32'(lives), 32'(8'h33));
    check("abort_ovr_clear", 32'(frame_overrun), 32'(0));

    // randomized frames
    for (int f = 0; f < 160; f++) begin
      if (m_go || $urandom_range(0, 24) == 0) do_reset();
      random_scene();
      pulse_tick();
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        repeat ($urandom_range(0, 9)) @(negedge clock);
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
      end else if (mode == 1) begin
        repeat ($urandom_range(0, 12)) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 8)) @(negedge clock);
        random_scene();
      end
      repeat (P + 2) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
